// File: rtl/gnrc_upsizer.sv
// Stream width up-converter: packs RATIO consecutive DW-bit beats into one registered
// DW*RATIO-bit word, with early termination (last_i + keep mask) and synchronous flush.
module gnrc_upsizer #(
    parameter int unsigned DW    = 16,
    parameter int unsigned RATIO = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic [DW-1:0]       data_i,
    input  logic                last_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [DW*RATIO-1:0] data_o,
    output logic [RATIO-1:0]    keep_o,
    output logic                last_o,
    input  logic                ready_i
);
    localparam int unsigned CW = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int unsigned WW = DW * RATIO;

    if (RATIO < 2) begin : g_ratio_check
        $error("gnrc_upsizer: RATIO must be >= 2");
    end

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    acc_q, acc_d;
    logic [RATIO-1:0] acc_keep_q, acc_keep_d;
    logic             valid_q, valid_d;
    logic [WW-1:0]    data_q, data_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic             last_q, last_d;

    logic             accept;
    logic             closing;
    logic [WW-1:0]    acc_new;
    logic [RATIO-1:0] keep_new;

    always_comb begin
        ready_o  = ~flush_i & ~rst_i & (~valid_q | ready_i);
        accept   = valid_i & ready_o;
        closing  = (cnt_q == CW'(RATIO - 1)) | last_i;

        // Current beat merged into the accumulator at lane cnt.
        acc_new  = acc_q;
        keep_new = acc_keep_q;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt_q == CW'(k)) begin
                acc_new[k*DW +: DW] = data_i;
                keep_new[k]         = 1'b1;
            end
        end

        cnt_d      = cnt_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        valid_d    = valid_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;

        if (flush_i) begin
            cnt_d      = '0;
            acc_d      = '0;
            acc_keep_d = '0;
            valid_d    = 1'b0;
            data_d     = '0;
            keep_d     = '0;
            last_d     = 1'b0;
        end else begin
            if (valid_q & ready_i) begin
                valid_d = 1'b0;
            end
            // A closing beat overrides the drain above, so back-to-back words have no bubble.
            if (accept) begin
                if (closing) begin
                    valid_d    = 1'b1;
                    data_d     = acc_new;
                    keep_d     = keep_new;
                    last_d     = last_i;
                    cnt_d      = '0;
                    acc_d      = '0;
                    acc_keep_d = '0;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    acc_d      = acc_new;
                    acc_keep_d = keep_new;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_gnrc_upsizer.sv
// Bench for gnrc_upsizer: hand-computed vector table, directed corner sequences,
// and randomized traffic against a queue-based packing model.
module tb_gnrc_upsizer;
    localparam int unsigned DW    = 16;
    localparam int unsigned RATIO = 4;
    localparam int unsigned WW    = DW * RATIO;

    logic             clk = 1'b0;
    logic             rst_i, flush_i, valid_i, last_i, ready_i;
    logic [DW-1:0]    data_i;
    logic             ready_o, valid_o, last_o;
    logic [WW-1:0]    data_o;
    logic [RATIO-1:0] keep_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    gnrc_upsizer #(.DW(DW), .RATIO(RATIO)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .keep_o  (keep_o),
        .last_o  (last_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: beats of the open packet in a queue, output word as plain values.
    logic [DW-1:0]    part_q[$];
    logic             m_valid = 1'b0;
    logic [WW-1:0]    m_data  = '0;
    logic [RATIO-1:0] m_keep  = '0;
    logic             m_last  = 1'b0;

    function automatic logic m_ready(input logic rst, input logic flush, input logic rdy);
        return !rst && !flush && (!m_valid || rdy);
    endfunction

    task automatic model_edge(input logic rst, input logic flush, input logic valid,
                              input logic [DW-1:0] data, input logic last, input logic rdy);
        logic taken;
        if (rst || flush) begin
            part_q.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_keep  = '0;
            m_last  = 1'b0;
        end else begin
            taken = valid && m_ready(rst, flush, rdy);
            if (m_valid && rdy) m_valid = 1'b0;
            if (taken) begin
                part_q.push_back(data);
                if (part_q.size() == RATIO || last) begin
                    m_data = '0;
                    m_keep = '0;
                    for (int i = 0; i < part_q.size(); i++) begin
                        m_data = m_data | (WW'(part_q[i]) << (i * DW));
                        m_keep[i] = 1'b1;
                    end
                    m_last  = last;
                    m_valid = 1'b1;
                    part_q.delete();
                end
            end
        end
    endtask

    task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic flush, input logic valid,
                         input logic [DW-1:0] data, input logic last, input logic rdy);
        @(negedge clk);
        rst_i   = rst;
        flush_i = flush;
        valid_i = valid;
        data_i  = data;
        last_i  = last;
        ready_i = rdy;
        #1;
    endtask

    // One cycle checked against the model: ready_o before the edge, outputs after it.
    task automatic step(input logic rst, input logic flush, input logic valid,
                        input logic [DW-1:0] data, input logic last, input logic rdy);
        drive(rst, flush, valid, data, last, rdy);
        check("ready_o", ready_o, m_ready(rst, flush, rdy));
        @(posedge clk);
        model_edge(rst, flush, valid, data, last, rdy);
        #1;
        check("valid_o", valid_o, m_valid);
        check("data_o", data_o, m_data);
        check("keep_o", keep_o, m_keep);
        check("last_o", last_o, m_last);
    endtask

    typedef struct {
        logic          rst, flush, valid;
        logic [DW-1:0] data;
        logic          last, rdy;
        logic          e_ready, e_valid;
        logic [WW-1:0] e_data;
        logic [3:0]    e_keep;
        logic          e_last;
    } vec_t;

    vec_t tbl[20];
    logic [WW-1:0] held;
    int unsigned   words;

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b1;

        //          rst flush vld data     lst rdy  ready vld  data                    keep   last
        tbl[0]  = '{1, 0, 1, 16'h0055, 0, 1,  0, 0, 64'h0,                 4'h0, 0};
        tbl[1]  = '{1, 0, 1, 16'h0055, 0, 1,  0, 0, 64'h0,                 4'h0, 0};
        tbl[2]  = '{0, 0, 1, 16'h0001, 0, 1,  1, 0, 64'h0,                 4'h0, 0};
        tbl[3]  = '{0, 0, 1, 16'h0002, 0, 1,  1, 0, 64'h0,                 4'h0, 0};
        tbl[4]  = '{0, 0, 1, 16'h0003, 0, 1,  1, 0, 64'h0,                 4'h0, 0};
        tbl[5]  = '{0, 0, 1, 16'h0004, 0, 1,  1, 1, 64'h0004_0003_0002_0001, 4'hF, 0};
        tbl[6]  = '{0, 0, 1, 16'h0005, 0, 1,  1, 0, 64'h0004_0003_0002_0001, 4'hF, 0};
        tbl[7]  = '{0, 0, 1, 16'h0006, 0, 1,  1, 0, 64'h0004_0003_0002_0001, 4'hF, 0};
        tbl[8]  = '{0, 0, 1, 16'h0007, 0, 1,  1, 0, 64'h0004_0003_0002_0001, 4'hF, 0};
        tbl[9]  = '{0, 0, 1, 16'h0008, 0, 1,  1, 1, 64'h0008_0007_0006_0005, 4'hF, 0};
        tbl[10] = '{0, 0, 1, 16'h00A1, 0, 1,  1, 0, 64'h0008_0007_0006_0005, 4'hF, 0};
        tbl[11] = '{0, 0, 1, 16'h00A2, 1, 1,  1, 1, 64'h0000_0000_00A2_00A1, 4'h3, 1};
        tbl[12] = '{0, 0, 1, 16'h0011, 0, 1,  1, 0, 64'h0000_0000_00A2_00A1, 4'h3, 1};
        tbl[13] = '{0, 0, 1, 16'h0022, 0, 1,  1, 0, 64'h0000_0000_00A2_00A1, 4'h3, 1};
        tbl[14] = '{0, 1, 1, 16'h0099, 0, 1,  0, 0, 64'h0,                 4'h0, 0};
        tbl[15] = '{0, 0, 1, 16'h0033, 0, 1,  1, 0, 64'h0,                 4'h0, 0};
        tbl[16] = '{0, 0, 1, 16'h0034, 0, 1,  1, 0, 64'h0,                 4'h0, 0};
        tbl[17] = '{0, 0, 1, 16'h0035, 0, 1,  1, 0, 64'h0,                 4'h0, 0};
        tbl[18] = '{0, 0, 1, 16'h0036, 0, 1,  1, 1, 64'h0036_0035_0034_0033, 4'hF, 0};
        tbl[19] = '{0, 0, 0, 16'h0000, 0, 1,  1, 0, 64'h0036_0035_0034_0033, 4'hF, 0};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].rdy);
            check($sformatf("vec%0d ready_o", i), ready_o, tbl[i].e_ready);
            @(posedge clk);
            model_edge(tbl[i].rst, tbl[i].flush, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].rdy);
            #1;
            check($sformatf("vec%0d valid_o", i), valid_o, tbl[i].e_valid);
            check($sformatf("vec%0d data_o", i), data_o, tbl[i].e_data);
            check($sformatf("vec%0d keep_o", i), keep_o, tbl[i].e_keep);
            check($sformatf("vec%0d last_o", i), last_o, tbl[i].e_last);
        end

        // Backpressure: finished word held for 5 cycles while a beat waits upstream.
        for (int i = 1; i <= 4; i++) step(0, 0, 1, DW'(16'h00B0 + i), 0, 1);
        held = data_o;
        check("bp word", held, 64'h00B4_00B3_00B2_00B1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 16'h00B5, 0, 0);
            check("bp ready_o low", ready_o, 1'b0);
            check("bp data stable", data_o, held);
        end
        for (int i = 5; i <= 8; i++) step(0, 0, 1, DW'(16'h00B0 + i), 0, 1);
        check("bp next word", data_o, 64'h00B8_00B7_00B6_00B5);
        step(0, 0, 0, 16'h0000, 0, 1);

        // Back-to-back full words: 12 beats give exactly 3 words.
        words = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, DW'(16'h0C00 + i), 0, 1);
            if (valid_o === 1'b1) words++;
        end
        check("b2b word count", WW'(words), WW'(3));

        // Single-beat packets each cycle: transfer and reload together, no bubble.
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, DW'(16'h0D00 + i), 1, 1);
            check("no bubble valid_o", valid_o, 1'b1);
        end
        step(0, 0, 0, 16'h0000, 0, 1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) == 0), ($urandom_range(49) == 0),
                 ($urandom_range(3) != 0), DW'($urandom), ($urandom_range(4) == 0),
                 ($urandom_range(3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
